aes_stream_ctrl: RTL and testbench

Parametrised, length-driven successor to the single-channel AES memory sequencer. It walks a buffer of `num_blocks_in` 128-bit blocks in the shared word-addressed scratchpad and feeds each block to an external `aes_core` through an init/valid handshake. Results are written to the output region. ECB and CBC chaining are supported in both directions, and the block adds explicit start/done/abort control, error reporting and a configurable memory read latency.

---
 rtl/aes_stream_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_aes_stream_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_ctrl.sv
// -----------------------------------------------------------------------------
// aes_stream_ctrl
//
// Length-driven block sequencer between a word-addressed scratchpad and an
// external AES core. A job walks num_blocks_in 128-bit blocks starting at
// IN_BASE, sends each block to the core, optionally applies CBC chaining in
// either direction, and writes the results starting at OUT_BASE.
//
// Core handshake: core_init_out is a one-cycle request with core_data_out and
// core_mode_out held stable from the init cycle until the result arrives.
// The core answers with core_valid_in high for the cycle in which core_data_in
// holds the result. The result is taken only while in WAIT, and valid seen in
// any other state is dropped.
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-low reset
//   start_in, abort_in      job start pulse (idle only), synchronous abort
//   decrypt_in, cbc_in      direction and chaining mode, sampled at start
//   num_blocks_in, iv_in    block count and CBC IV, sampled at start
//   mem_addr_out            scratchpad word address (decoded from state)
//   mem_we_out              byte write enables, 4'hF during write-back only
//   mem_wdata_out           write data, zero outside write-back
//   mem_rdata_in            read data, MEM_RD_LAT cycles after the address
//   core_init_out           one-cycle core start
//   core_mode_out           core direction, 1 = decrypt
//   core_data_out           block presented to the core
//   core_data_in            core result
//   core_valid_in           core result valid
//   busy_out                job in progress
//   done_out                one-cycle completion pulse
//   error_out               sticky error for an oversized request
//   blocks_done_out         blocks written back in the current job
//   dbg_state_out           current FSM state encoding
// -----------------------------------------------------------------------------
module aes_stream_ctrl #(
   parameter int ADDR_W     = 10,
   parameter int IN_BASE    = 0,
   parameter int OUT_BASE   = 257,
   parameter int MAX_BLOCKS = 64,
   parameter int MEM_RD_LAT = 1
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start_in,
   input  logic              abort_in,
   input  logic              decrypt_in,
   input  logic              cbc_in,
   input  logic [7:0]        num_blocks_in,
   input  logic [127:0]      iv_in,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [3:0]        mem_we_out,
   output logic [31:0]       mem_wdata_out,
   input  logic [31:0]       mem_rdata_in,
   output logic              core_init_out,
   output logic              core_mode_out,
   output logic [127:0]      core_data_out,
   input  logic [127:0]      core_data_in,
   input  logic              core_valid_in,
   output logic              busy_out,
   output logic              done_out,
   output logic              error_out,
   output logic [7:0]        blocks_done_out,
   output logic [2:0]        dbg_state_out
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_WB    = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   localparam logic [ADDR_W-1:0] IN_BASE_A  = ADDR_W'(IN_BASE);
   localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);
   localparam logic [8:0]        MAX_BLK    = 9'(MAX_BLOCKS);
   localparam logic [1:0]        LAT_LAST   = 2'(MEM_RD_LAT);

   state_e         state_q, state_d;
   logic [7:0]     blk_q, blk_d;
   logic [1:0]     word_q, word_d;
   logic [1:0]     lat_q, lat_d;
   logic [7:0]     num_q, num_d;
   logic           dec_q, dec_d;
   logic           cbc_q, cbc_d;
   logic [127:0]   chain_q, chain_d;
   logic [127:0]   gather_q, gather_d;
   logic [127:0]   result_q, result_d;
   logic           core_init_q, core_init_d;
   logic           core_mode_q, core_mode_d;
   logic [127:0]   core_data_q, core_data_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           error_q, error_d;
   logic [7:0]     bdone_q, bdone_d;

   logic [127:0]   gather_upd;
   logic [31:0]    res_word;
   logic           rd_beat;
   logic           last_blk;
   logic           cbc_enc;
   logic           cbc_dec;

   assign rd_beat  = (lat_q == LAT_LAST);
   assign last_blk = (blk_q == (num_q - 8'd1));
   assign cbc_enc  = cbc_q & ~dec_q;
   assign cbc_dec  = cbc_q & dec_q;

   // Block buffer with the word currently being read merged in. On the last
   // read beat this is the complete block, so START can present it at once.
   always_comb begin
      gather_upd = gather_q;
      case (word_q)
         2'd0:    gather_upd[127:96] = mem_rdata_in;
         2'd1:    gather_upd[95:64]  = mem_rdata_in;
         2'd2:    gather_upd[63:32]  = mem_rdata_in;
         default: gather_upd[31:0]   = mem_rdata_in;
      endcase
   end

   always_comb begin
      case (word_q)
         2'd0:    res_word = result_q[127:96];
         2'd1:    res_word = result_q[95:64];
         2'd2:    res_word = result_q[63:32];
         default: res_word = result_q[31:0];
      endcase
   end

   always_comb begin
      state_d     = state_q;
      blk_d       = blk_q;
      word_d      = word_q;
      lat_d       = lat_q;
      num_d       = num_q;
      dec_d       = dec_q;
      cbc_d       = cbc_q;
      chain_d     = chain_q;
      gather_d    = gather_q;
      result_d    = result_q;
      core_mode_d = core_mode_q;
      error_d     = error_q;
      bdone_d     = bdone_q;

      case (state_q)
         ST_IDLE: begin
            if (start_in && !abort_in) begin
               error_d = 1'b0;
               bdone_d = 8'd0;
               blk_d   = 8'd0;
               word_d  = 2'd0;
               lat_d   = 2'd0;
               if (num_blocks_in == 8'd0) begin
                  state_d = ST_DONE;
               end else if ({1'b0, num_blocks_in} > MAX_BLK) begin
                  error_d = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  dec_d       = decrypt_in;
                  cbc_d       = cbc_in;
                  num_d       = num_blocks_in;
                  chain_d     = iv_in;
                  core_mode_d = decrypt_in;
                  state_d     = ST_RD;
               end
            end
         end
         ST_RD: begin
            // One word outstanding: the address is held until its data beat.
            if (rd_beat) begin
               gather_d = gather_upd;
               lat_d    = 2'd0;
               word_d   = word_q + 2'd1;
               if (word_q == 2'd3) begin
                  state_d = ST_START;
               end
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (core_valid_in) begin
               if (cbc_dec) begin
                  result_d = core_data_in ^ chain_q;
                  chain_d  = gather_q;
               end else begin
                  result_d = core_data_in;
                  if (cbc_enc) begin
                     chain_d = core_data_in;
                  end
               end
               word_d  = 2'd0;
               state_d = ST_WB;
            end
         end
         ST_WB: begin
            word_d = word_q + 2'd1;
            if (word_q == 2'd3) begin
               bdone_d = bdone_q + 8'd1;
               if (last_blk) begin
                  state_d = ST_DONE;
               end else begin
                  blk_d   = blk_q + 8'd1;
                  state_d = ST_RD;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort discards the block in flight; the write-back count is frozen.
      if (abort_in && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         bdone_d = bdone_q;
      end

      // Registered outputs follow the state being entered.
      core_init_d = (state_d == ST_START);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
      if (state_d == ST_START) begin
         core_data_d = gather_upd ^ (cbc_enc ? chain_q : 128'd0);
      end else if (state_d == ST_WAIT) begin
         core_data_d = core_data_q;
      end else begin
         core_data_d = 128'd0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= ST_IDLE;
         blk_q       <= 8'd0;
         word_q      <= 2'd0;
         lat_q       <= 2'd0;
         num_q       <= 8'd0;
         dec_q       <= 1'b0;
         cbc_q       <= 1'b0;
         chain_q     <= 128'd0;
         gather_q    <= 128'd0;
         result_q    <= 128'd0;
         core_init_q <= 1'b0;
         core_mode_q <= 1'b0;
         core_data_q <= 128'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         bdone_q     <= 8'd0;
      end else begin
         state_q     <= state_d;
         blk_q       <= blk_d;
         word_q      <= word_d;
         lat_q       <= lat_d;
         num_q       <= num_d;
         dec_q       <= dec_d;
         cbc_q       <= cbc_d;
         chain_q     <= chain_d;
         gather_q    <= gather_d;
         result_q    <= result_d;
         core_init_q <= core_init_d;
         core_mode_q <= core_mode_d;
         core_data_q <= core_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         bdone_q     <= bdone_d;
      end
   end

   // Memory side decodes straight from state and counters so that an abort
   // can suppress the write in the very cycle it arrives.
   always_comb begin
      mem_addr_out = '0;
      if (state_q == ST_RD) begin
         mem_addr_out = IN_BASE_A + ADDR_W'({blk_q, word_q});
      end else if (state_q == ST_WB) begin
         mem_addr_out = OUT_BASE_A + ADDR_W'({blk_q, word_q});
      end
   end

   assign mem_we_out      = ((state_q == ST_WB) && !abort_in) ? 4'hF : 4'h0;
   assign mem_wdata_out   = (state_q == ST_WB) ? res_word : 32'd0;
   assign core_init_out   = core_init_q & ~abort_in;
   assign core_mode_out   = core_mode_q;
   assign core_data_out   = core_data_q;
   assign busy_out        = busy_q;
   assign done_out        = done_q;
   assign error_out       = error_q;
   assign blocks_done_out = bdone_q;
   assign dbg_state_out   = state_q;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_stream_ctrl
//
// Directed bench for aes_stream_ctrl. Two instances share the job inputs:
// dut 0 uses a one-cycle memory read latency, dut 1 a three-cycle latency.
// Each has its own scratchpad (input region preloaded by the stimulus, output
// region written only by the DUT) and its own core model that returns the
// inverted block five cycles after init.
// -----------------------------------------------------------------------------
module tb_aes_stream_ctrl;

   localparam int AW = 10;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         start_s [2];
   logic         abort_s;
   logic         decrypt_s;
   logic         cbc_s;
   logic [7:0]   num_s;
   logic [127:0] iv_s;
   logic         stray_s;
   logic         clr_req;

   logic [AW-1:0] addr_w  [2];
   logic [3:0]    we_w    [2];
   logic [31:0]   wdata_w [2];
   logic [31:0]   rdata_w [2];
   logic          init_w  [2];
   logic          mode_w  [2];
   logic [127:0]  cdo_w   [2];
   logic [127:0]  cdi_w   [2];
   logic          cval_w  [2];
   logic          busy_w  [2];
   logic          done_w  [2];
   logic          err_w   [2];
   logic [7:0]    bd_w    [2];
   logic [2:0]    st_w    [2];

   // ---------------- memory and core models ----------------
   logic [31:0]  in_mem  [2][1024];
   logic [31:0]  out_mem [2][1024];
   logic [AW-1:0] p0 = '0;
   logic [AW-1:0] p1 [3] = '{10'd0, 10'd0, 10'd0};
   logic [3:0]   cd [2] = '{4'd0, 4'd0};
   logic [127:0] res [2] = '{128'd0, 128'd0};
   logic         last_mode [2] = '{1'b0, 1'b0};
   int           wr_cnt [2] = '{0, 0};
   int           done_cnt [2] = '{0, 0};

   assign rdata_w[0] = in_mem[0][p0];
   assign rdata_w[1] = in_mem[1][p1[2]];
   assign cdi_w[0]   = res[0];
   assign cdi_w[1]   = res[1];
   assign cval_w[0]  = (cd[0] == 4'd1) | stray_s;
   assign cval_w[1]  = (cd[1] == 4'd1);

   always @(posedge clk) begin
      p0    <= addr_w[0];
      p1[0] <= addr_w[1];
      p1[1] <= p1[0];
      p1[2] <= p1[1];
      for (int i = 0; i < 2; i++) begin
         if (clr_req) begin
            for (int a = 0; a < 1024; a++) out_mem[i][a] = 32'hDEADBEEF;
         end
         if (we_w[i] != 4'h0) begin
            out_mem[i][addr_w[i]] = wdata_w[i];
            wr_cnt[i] <= wr_cnt[i] + 1;
         end
         if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
         if (init_w[i]) begin
            cd[i]        <= 4'd5;
            res[i]       <= ~cdo_w[i];
            last_mode[i] <= mode_w[i];
         end else if (cd[i] != 4'd0) begin
            cd[i] <= cd[i] - 4'd1;
         end
      end
   end

   // ---------------- DUTs ----------------
   aes_stream_ctrl #(.ADDR_W(AW), .IN_BASE(0), .OUT_BASE(257), .MAX_BLOCKS(64), .MEM_RD_LAT(1)) u_dut1 (
      .clk_in(clk), .rst_in(rst_n), .start_in(start_s[0]), .abort_in(abort_s),
      .decrypt_in(decrypt_s), .cbc_in(cbc_s), .num_blocks_in(num_s), .iv_in(iv_s),
      .mem_addr_out(addr_w[0]), .mem_we_out(we_w[0]), .mem_wdata_out(wdata_w[0]),
      .mem_rdata_in(rdata_w[0]), .core_init_out(init_w[0]), .core_mode_out(mode_w[0]),
      .core_data_out(cdo_w[0]), .core_data_in(cdi_w[0]), .core_valid_in(cval_w[0]),
      .busy_out(busy_w[0]), .done_out(done_w[0]), .error_out(err_w[0]),
      .blocks_done_out(bd_w[0]), .dbg_state_out(st_w[0])
   );

   aes_stream_ctrl #(.ADDR_W(AW), .IN_BASE(0), .OUT_BASE(257), .MAX_BLOCKS(64), .MEM_RD_LAT(3)) u_dut3 (
      .clk_in(clk), .rst_in(rst_n), .start_in(start_s[1]), .abort_in(1'b0),
      .decrypt_in(decrypt_s), .cbc_in(cbc_s), .num_blocks_in(num_s), .iv_in(iv_s),
      .mem_addr_out(addr_w[1]), .mem_we_out(we_w[1]), .mem_wdata_out(wdata_w[1]),
      .mem_rdata_in(rdata_w[1]), .core_init_out(init_w[1]), .core_mode_out(mode_w[1]),
      .core_data_out(cdo_w[1]), .core_data_in(cdi_w[1]), .core_valid_in(cval_w[1]),
      .busy_out(busy_w[1]), .done_out(done_w[1]), .error_out(err_w[1]),
      .blocks_done_out(bd_w[1]), .dbg_state_out(st_w[1])
   );

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q [$];
   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_blk(input logic [127:0] v);
      exp_q.push_back(v[127:96]);
      exp_q.push_back(v[95:64]);
      exp_q.push_back(v[63:32]);
      exp_q.push_back(v[31:0]);
   endtask

   task automatic check_out(input int i, input int n_words);
      logic [31:0] w;
      for (int k = 0; k < n_words; k++) begin
         w = exp_q.pop_front();
         chk($sformatf("dut%0d_out[%0d]", i, 257 + k), {160'd0, out_mem[i][257 + k]}, {160'd0, w});
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic load_blk(input int i, input int blk, input logic [127:0] v);
      in_mem[i][4*blk + 0] = v[127:96];
      in_mem[i][4*blk + 1] = v[95:64];
      in_mem[i][4*blk + 2] = v[63:32];
      in_mem[i][4*blk + 3] = v[31:0];
   endtask

   task automatic clear_out();
      @(negedge clk); clr_req = 1'b1;
      @(negedge clk); clr_req = 1'b0;
   endtask

   // Starts a job and returns the cycle of done_out counted from the cycle
   // after the start cycle (1 = the cycle immediately following start).
   task automatic run(input int i, input logic dec, input logic cbc, input logic [7:0] n,
                      input logic [127:0] iv, output int lat);
      @(negedge clk);
      decrypt_s = dec; cbc_s = cbc; num_s = n; iv_s = iv; start_s[i] = 1'b1;
      @(negedge clk);
      start_s[i] = 1'b0;
      lat = 1;
      while (!done_w[i] && lat < 400) begin
         @(negedge clk);
         lat++;
      end
   endtask

   function automatic logic [191:0] out_vec(input int i);
      return {2'b00, addr_w[i], we_w[i], wdata_w[i], init_w[i], mode_w[i], cdo_w[i],
              busy_w[i], done_w[i], err_w[i], bd_w[i], st_w[i]};
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      int lat;
      int w0;
      int d0;
      int cnt;
      int g;

      rst_n = 1'b0; start_s[0] = 1'b0; start_s[1] = 1'b0; abort_s = 1'b0;
      decrypt_s = 1'b0; cbc_s = 1'b0; num_s = 8'd0; iv_s = 128'd0;
      stray_s = 1'b0; clr_req = 1'b0;
      for (int i = 0; i < 2; i++)
         for (int a = 0; a < 1024; a++) in_mem[i][a] = 32'd0;

      #12;
      chk("reset_outputs_dut1", out_vec(0), 192'd0);
      chk("reset_outputs_dut3", out_vec(1), 192'd0);
      @(negedge clk); rst_n = 1'b1;

      // ECB encrypt, one block: 1 + 8 + 1 + 5 + 4 cycles to the DONE cycle.
      load_blk(0, 0, 128'h00112233_44556677_8899aabb_ccddeeff);
      clear_out();
      w0 = wr_cnt[0];
      run(0, 1'b0, 1'b0, 8'd1, 128'd0, lat);
      chk("ecb_done_latency", 192'(lat), 192'd19);
      chk("ecb_blocks_done", {184'd0, bd_w[0]}, 192'd1);
      chk("ecb_core_mode", {191'd0, last_mode[0]}, 192'd0);
      @(negedge clk);
      chk("ecb_busy_after", {191'd0, busy_w[0]}, 192'd0);
      chk("ecb_write_count", 192'(wr_cnt[0] - w0), 192'd4);
      push_blk(128'hffeeddcc_bbaa9988_77665544_33221100);
      check_out(0, 4);

      // CBC encrypt, two zero blocks, IV = 1.
      load_blk(0, 0, 128'd0);
      load_blk(0, 1, 128'd0);
      clear_out();
      run(0, 1'b0, 1'b1, 8'd2, 128'd1, lat);
      chk("cbc_enc_latency", 192'(lat), 192'd37);
      chk("cbc_enc_blocks_done", {184'd0, bd_w[0]}, 192'd2);
      push_blk(128'hffffffff_ffffffff_ffffffff_fffffffe);
      push_blk(128'h00000000_00000000_00000000_00000001);
      check_out(0, 8);

      // CBC decrypt of that ciphertext restores zeros, on both latencies.
      for (int i = 0; i < 2; i++) begin
         load_blk(i, 0, 128'hffffffff_ffffffff_ffffffff_fffffffe);
         load_blk(i, 1, 128'h00000000_00000000_00000000_00000001);
      end
      clear_out();
      run(0, 1'b1, 1'b1, 8'd2, 128'd1, lat);
      chk("cbc_dec_latency", 192'(lat), 192'd37);
      chk("cbc_dec_core_mode", {191'd0, last_mode[0]}, 192'd1);
      push_blk(128'd0);
      push_blk(128'd0);
      check_out(0, 8);
      run(1, 1'b1, 1'b1, 8'd2, 128'd1, lat);
      chk("cbc_dec_lat3_latency", 192'(lat), 192'd53);
      chk("cbc_dec_lat3_blocks_done", {184'd0, bd_w[1]}, 192'd2);
      push_blk(128'd0);
      push_blk(128'd0);
      check_out(1, 8);

      // Zero-length and oversized requests.
      w0 = wr_cnt[0];
      run(0, 1'b0, 1'b0, 8'd0, 128'd0, lat);
      chk("zero_len_latency", 192'(lat), 192'd1);
      chk("zero_len_error", {191'd0, err_w[0]}, 192'd0);
      chk("zero_len_blocks_done", {184'd0, bd_w[0]}, 192'd0);
      run(0, 1'b0, 1'b0, 8'd65, 128'd0, lat);
      chk("oversize_latency", 192'(lat), 192'd1);
      chk("oversize_error", {191'd0, err_w[0]}, 192'd1);
      chk("no_write_zero_or_oversize", 192'(wr_cnt[0] - w0), 192'd0);

      // Legal start clears the error; a start while busy is ignored.
      load_blk(0, 0, 128'h01234567_89abcdef_fedcba98_76543210);
      clear_out();
      w0 = wr_cnt[0];
      @(negedge clk);
      decrypt_s = 1'b0; cbc_s = 1'b0; num_s = 8'd1; iv_s = 128'd0; start_s[0] = 1'b1;
      @(negedge clk); start_s[0] = 1'b0;
      chk("error_cleared", {191'd0, err_w[0]}, 192'd0);
      @(negedge clk); @(negedge clk);
      num_s = 8'd3; cbc_s = 1'b1; start_s[0] = 1'b1;
      @(negedge clk); start_s[0] = 1'b0;
      lat = 4;
      while (!done_w[0] && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      chk("busy_start_latency", 192'(lat), 192'd19);
      chk("busy_start_blocks_done", {184'd0, bd_w[0]}, 192'd1);
      @(negedge clk); @(negedge clk);
      chk("busy_start_write_count", 192'(wr_cnt[0] - w0), 192'd4);
      chk("busy_start_idle", {189'd0, st_w[0]}, 192'd0);
      push_blk(128'hfedcba98_76543210_01234567_89abcdef);
      check_out(0, 4);

      // Abort during WAIT of block 2 of a four-block job.
      for (int b = 0; b < 4; b++) load_blk(0, b, {4{32'h0f0f0f00 + 32'(b)}});
      clear_out();
      w0 = wr_cnt[0];
      d0 = done_cnt[0];
      @(negedge clk);
      decrypt_s = 1'b0; cbc_s = 1'b0; num_s = 8'd4; start_s[0] = 1'b1;
      @(negedge clk); start_s[0] = 1'b0;
      cnt = 0; g = 0;
      while (cnt < 3 && g < 500) begin
         @(negedge clk);
         g++;
         if (init_w[0]) cnt++;
      end
      chk("abort_third_init_seen", 192'(cnt), 192'd3);
      @(negedge clk); @(negedge clk);
      abort_s = 1'b1;
      @(negedge clk); abort_s = 1'b0;
      chk("abort_busy_low", {191'd0, busy_w[0]}, 192'd0);
      stray_s = 1'b1;
      @(negedge clk); stray_s = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort_blocks_done", {184'd0, bd_w[0]}, 192'd2);
      chk("abort_write_count", 192'(wr_cnt[0] - w0), 192'd8);
      chk("abort_no_done", 192'(done_cnt[0] - d0), 192'd0);
      chk("abort_stray_valid_idle", {189'd0, st_w[0]}, 192'd0);
      push_blk(~{4{32'h0f0f0f00}});
      push_blk(~{4{32'h0f0f0f01}});
      check_out(0, 8);

      // Abort in the first write-back cycle blocks that write.
      load_blk(0, 0, 128'h11112222_33334444_55556666_77778888);
      w0 = wr_cnt[0];
      @(negedge clk);
      num_s = 8'd1; start_s[0] = 1'b1;
      @(negedge clk); start_s[0] = 1'b0;
      g = 0;
      while (we_w[0] == 4'h0 && g < 500) begin
         @(negedge clk);
         g++;
      end
      abort_s = 1'b1;
      #1;
      chk("abort_wb_we_gated", {188'd0, we_w[0]}, 192'd0);
      @(negedge clk); abort_s = 1'b0;
      chk("abort_wb_write_count", 192'(wr_cnt[0] - w0), 192'd0);
      chk("abort_wb_busy_low", {191'd0, busy_w[0]}, 192'd0);

      // Asynchronous reset in the middle of write-back.
      @(negedge clk);
      num_s = 8'd1; start_s[0] = 1'b1;
      @(negedge clk); start_s[0] = 1'b0;
      g = 0;
      while (we_w[0] == 4'h0 && g < 500) begin
         @(negedge clk);
         g++;
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("reset_mid_wb_outputs", out_vec(0), 192'd0);
      @(negedge clk); rst_n = 1'b1;

      // Fresh job after reset.
      load_blk(0, 0, 128'hcafef00d_0badc0de_13579bdf_2468ace0);
      clear_out();
      run(0, 1'b0, 1'b0, 8'd1, 128'd0, lat);
      chk("post_reset_latency", 192'(lat), 192'd19);
      chk("post_reset_blocks_done", {184'd0, bd_w[0]}, 192'd1);
      push_blk(128'h35010ff2_f4523f21_eca86420_db97531f);
      check_out(0, 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
